// File: rtl/bus_frame_receiver.sv
// ============================================================================
//  Module   : bus_frame_receiver
//  Brief    : Deframes start/address/data/CRC-4 frames from a one-bit serial
//             bus and delivers matching 64-bit payloads.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_frame_receiver #(
    parameter logic [3:0] MY_ADDR = 4'd1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        bus_in,
    input  logic        enable,
    output logic [63:0] data_out,
    output logic        data_valid,
    output logic        crc_error,
    output logic        busy,
    output logic [7:0]  good_count,
    output logic [7:0]  err_count
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ADDR  = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_CRCF  = 3'd3;
    localparam logic [2:0] c_ST_CHECK = 3'd4;

    // Bit counter runs 0..71 across address, data and CRC fields.
    localparam logic [6:0] c_LAST_ADDR = 7'd3;
    localparam logic [6:0] c_LAST_DATA = 7'd67;
    localparam logic [6:0] c_LAST_CRC  = 7'd71;
    localparam logic [3:0] c_CRC_POLY  = 4'b0011;
    localparam logic [7:0] c_CNT_MAX   = 8'hFF;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [6:0]  r_bit_cnt;
    logic [3:0]  r_crc;
    logic [3:0]  r_addr;
    logic [63:0] r_data;
    logic [3:0]  r_rx_crc;

    logic        w_start;
    logic        w_fb;
    logic        w_last_bit;
    logic        w_addr_match;
    logic        w_crc_ok;
    logic        w_good;
    logic        w_bad;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_start)                   w_next_state = c_ST_ADDR;
            c_ST_ADDR:  if (r_bit_cnt == c_LAST_ADDR)  w_next_state = c_ST_DATA;
            c_ST_DATA:  if (r_bit_cnt == c_LAST_DATA)  w_next_state = c_ST_CRCF;
            c_ST_CRCF:  if (r_bit_cnt == c_LAST_CRC)   w_next_state = c_ST_CHECK;
            c_ST_CHECK:                                w_next_state = c_ST_IDLE;
            default:                                   w_next_state = c_ST_IDLE;
        endcase
    end

    // Output / decode logic
    always_comb begin
        busy         = (r_state != c_ST_IDLE);
        w_start      = (r_state == c_ST_IDLE) && enable && bus_in;
        w_fb         = r_crc[3] ^ bus_in;
        w_last_bit   = (r_state == c_ST_CRCF) && (r_bit_cnt == c_LAST_CRC);
        w_addr_match = (r_addr == MY_ADDR);
        // The final CRC bit is still on the bus at the decision edge.
        w_crc_ok     = ({r_rx_crc[2:0], bus_in} == r_crc);
        w_good       = w_last_bit && w_addr_match && w_crc_ok;
        w_bad        = w_last_bit && w_addr_match && !w_crc_ok;
    end

    // Datapath: shift registers, CRC, decision and counters
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bit_cnt  <= '0;
            r_crc      <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_rx_crc   <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            crc_error  <= 1'b0;
            good_count <= '0;
            err_count  <= '0;
        end else begin
            data_valid <= w_good;
            crc_error  <= w_bad;

            case (r_state)
                c_ST_IDLE: begin
                    if (w_start) begin
                        r_bit_cnt <= '0;
                        r_crc     <= '0;
                    end
                end
                c_ST_ADDR: begin
                    r_addr    <= {r_addr[2:0], bus_in};
                    r_crc     <= {r_crc[2:0], 1'b0} ^ (w_fb ? c_CRC_POLY : 4'b0000);
                    r_bit_cnt <= r_bit_cnt + 7'd1;
                end
                c_ST_DATA: begin
                    r_data    <= {r_data[62:0], bus_in};
                    r_crc     <= {r_crc[2:0], 1'b0} ^ (w_fb ? c_CRC_POLY : 4'b0000);
                    r_bit_cnt <= r_bit_cnt + 7'd1;
                end
                c_ST_CRCF: begin
                    r_rx_crc  <= {r_rx_crc[2:0], bus_in};
                    r_bit_cnt <= r_bit_cnt + 7'd1;
                end
                default: ;
            endcase

            if (w_good) begin
                data_out <= r_data;
                if (good_count != c_CNT_MAX) good_count <= good_count + 8'd1;
            end
            if (w_bad && (err_count != c_CNT_MAX)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_frame_receiver.sv
// ============================================================================
//  Module   : tb_bus_frame_receiver
//  Brief    : Directed self-checking bench for bus_frame_receiver.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_frame_receiver;

    logic        clock;
    logic        reset;
    logic        bus_in;
    logic        enable;
    logic [63:0] data_out;
    logic        data_valid;
    logic        crc_error;
    logic        busy;
    logic [7:0]  good_count;
    logic [7:0]  err_count;

    int n_checks;
    int n_errors;
    int cyc;
    int valid_pulses;
    int err_pulses;
    int busy_cycles;
    int last_valid_cyc;
    int prev_valid_cyc;
    logic both_seen;

    bus_frame_receiver #(.MY_ADDR(4'd1)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus_in     (bus_in),
        .enable     (enable),
        .data_out   (data_out),
        .data_valid (data_valid),
        .crc_error  (crc_error),
        .busy       (busy),
        .good_count (good_count),
        .err_count  (err_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Pulse/busy monitors sample mid-cycle, away from the active edge.
    always @(negedge clock) begin
        if (data_valid) begin
            valid_pulses   <= valid_pulses + 1;
            prev_valid_cyc <= last_valid_cyc;
            last_valid_cyc <= cyc;
        end
        if (crc_error) err_pulses <= err_pulses + 1;
        if (busy) busy_cycles <= busy_cycles + 1;
        if (data_valid && crc_error) both_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives a 73-bit frame; returns #1 after the edge sampling the last CRC bit.
    task automatic send_frame(input logic [3:0] a, input logic [63:0] d,
                              input logic [3:0] c, output int start_cyc);
        logic [72:0] f;
        f = {1'b1, a, d, c};
        start_cyc = 0;
        for (int i = 72; i >= 0; i--) begin
            bus_in = f[i];
            @(posedge clock);
            #1;
            if (i == 72) start_cyc = cyc;
        end
        bus_in = 1'b0;
    endtask

    int s0, s1, vp, ep;

    initial begin
        n_checks = 0; n_errors = 0;
        cyc = 0; valid_pulses = 0; err_pulses = 0; busy_cycles = 0;
        last_valid_cyc = 0; prev_valid_cyc = 0; both_seen = 1'b0;
        reset = 1'b1; bus_in = 1'b0; enable = 1'b1;
        tick(); tick();
        check("rst_data_out",   data_out, 64'h0);
        check("rst_data_valid", 64'(data_valid), 64'h0);
        check("rst_crc_error",  64'(crc_error), 64'h0);
        check("rst_busy",       64'(busy), 64'h0);
        check("rst_good_count", 64'(good_count), 64'h0);
        check("rst_err_count",  64'(err_count), 64'h0);
        reset = 1'b0;
        tick();

        // Good frame: addr 1, data 1, CRC 6
        send_frame(4'd1, 64'h1, 4'h6, s0);
        check("good_busy_in_frame", 64'(busy), 64'h1);
        check("good_valid", 64'(data_valid), 64'h1);
        check("good_no_crc_err", 64'(crc_error), 64'h0);
        check("good_data_out", data_out, 64'h1);
        check("good_count1", 64'(good_count), 64'h1);
        tick();
        // Pulse occupies the cycle after E72, i.e. 72 edges past the start edge.
        check("good_latency", 64'(last_valid_cyc - s0), 64'd72);
        check("good_valid_width", 64'(data_valid), 64'h0);
        check("good_busy_fall", 64'(busy), 64'h0);

        // Bad CRC
        send_frame(4'd1, 64'h1, 4'h1, s0);
        check("bad_crc_error", 64'(crc_error), 64'h1);
        check("bad_no_valid", 64'(data_valid), 64'h0);
        tick();
        check("bad_err_count", 64'(err_count), 64'h1);
        check("bad_data_held", data_out, 64'h1);
        check("bad_good_count", 64'(good_count), 64'h1);
        check("bad_err_pulses", 64'(err_pulses), 64'd1);

        // Address mismatch: addr 2, data 0, CRC A
        tick();
        vp = valid_pulses; ep = err_pulses; busy_cycles = 0;
        send_frame(4'd2, 64'h0, 4'hA, s0);
        tick(); tick();
        check("mis_busy_cycles", 64'(busy_cycles), 64'd73);
        check("mis_no_valid", 64'(valid_pulses - vp), 64'd0);
        check("mis_no_err", 64'(err_pulses - ep), 64'd0);
        check("mis_good_count", 64'(good_count), 64'h1);
        check("mis_err_count", 64'(err_count), 64'h1);

        // Back-to-back, with a stray start bit in the CHECK cycle
        vp = valid_pulses;
        send_frame(4'd1, 64'h2, 4'h3, s0);
        check("b2b_data1", data_out, 64'h2);
        bus_in = 1'b1;
        tick();
        send_frame(4'd1, 64'h8000_0000_0000_0000, 4'hE, s1);
        tick();
        check("b2b_start_gap", 64'(s1 - s0), 64'd74);
        check("b2b_pulses", 64'(valid_pulses - vp), 64'd2);
        check("b2b_spacing", 64'(last_valid_cyc - prev_valid_cyc), 64'd74);
        check("b2b_data2", data_out, 64'h8000_0000_0000_0000);
        check("b2b_good_count", 64'(good_count), 64'd3);
        check("b2b_busy_idle", 64'(busy), 64'h0);

        // Reset at data bit 30 (edge E35)
        tick();
        vp = valid_pulses; ep = err_pulses;
        begin
            logic [72:0] f;
            f = {1'b1, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'h0};
            for (int i = 72; i >= 37; i--) begin
                bus_in = f[i];
                if (i == 37) reset = 1'b1;
                tick();
            end
        end
        check("mrst_data_out", data_out, 64'h0);
        check("mrst_busy", 64'(busy), 64'h0);
        check("mrst_good_count", 64'(good_count), 64'h0);
        check("mrst_err_count", 64'(err_count), 64'h0);
        check("mrst_valid", 64'(data_valid), 64'h0);
        reset = 1'b0; bus_in = 1'b0;
        tick(); tick();
        check("mrst_no_pulse", 64'(valid_pulses - vp + err_pulses - ep), 64'd0);
        send_frame(4'd1, 64'h1, 4'h6, s0);
        check("mrst_next_valid", 64'(data_valid), 64'h1);
        check("mrst_next_data", data_out, 64'h1);
        check("mrst_next_count", 64'(good_count), 64'h1);
        tick();

        // Enable low at start bit: frame ignored entirely
        enable = 1'b0; busy_cycles = 0; vp = valid_pulses;
        send_frame(4'd1, 64'h2, 4'h3, s0);
        tick();
        enable = 1'b1;
        check("en_busy_cycles", 64'(busy_cycles), 64'd0);
        check("en_no_valid", 64'(valid_pulses - vp), 64'd0);
        check("en_good_count", 64'(good_count), 64'h1);
        check("en_data_out", data_out, 64'h1);

        // Saturation: 256 more good frames from a count of 1
        for (int n = 0; n < 256; n++) begin
            send_frame(4'd1, 64'h1, 4'h6, s0);
            tick();
            if (n == 253) check("sat_reach_ff", 64'(good_count), 64'hFF);
        end
        check("sat_good_count", 64'(good_count), 64'hFF);
        check("sat_err_count", 64'(err_count), 64'h0);
        check("never_both", 64'(both_seen), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
